// File: rtl/bmp_stream_writer_if.sv
// Purpose: groups the video input, output stream and status signals of the BMP stream writer.
// Latency: none; this is wiring only.
// Backpressure: out_ready travels from the consumer to the writer; all other stream signals travel downstream.
interface bmp_stream_writer_if;
  logic        VSYNC;
  logic        HSYNC;
  logic [7:0]  DATA_R0;
  logic [7:0]  DATA_G0;
  logic [7:0]  DATA_B0;
  logic [7:0]  DATA_R1;
  logic [7:0]  DATA_G1;
  logic [7:0]  DATA_B1;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic        overflow;

  // Writer side
  modport slave (
    input  VSYNC, HSYNC,
    input  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    input  out_ready,
    output out_data, out_valid, frame_done, overflow
  );

  // Video source / stream consumer side
  modport master (
    output VSYNC, HSYNC,
    output DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    output out_ready,
    input  out_data, out_valid, frame_done, overflow
  );
endinterface

// File: rtl/bmp_stream_writer.sv
// Purpose: streams a 24bpp top-down BMP frame (54-byte header, then pixel pairs) as 6-byte beats.
// Latency: a pair pushed into an empty FIFO while streaming pixels is presented on the next cycle.
// Backpressure: out_ready stalls header and FIFO; a pair arriving at a full FIFO without a pop is dropped and flagged.
module bmp_stream_writer #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 16
) (
  input logic                HCLK,
  input logic                HRESET,
  bmp_stream_writer_if.slave bus
);

  localparam int NBEATS = WIDTH * HEIGHT / 2;
  localparam int CW     = $clog2(NBEATS + 1);
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Whole 54-byte header as one vector, byte k at bits [8k+7:8k] so fields land little-endian.
  function automatic logic [431:0] build_header(input int w, input int h);
    logic [431:0] hb;
    logic [31:0]  img;
    img = 32'(w * h * 3);
    hb  = '0;
    hb[0   +: 8]  = 8'h42;              // 'B'
    hb[8   +: 8]  = 8'h4D;              // 'M'
    hb[16  +: 32] = img + 32'd54;       // file size
    hb[80  +: 32] = 32'd54;             // pixel data offset
    hb[112 +: 32] = 32'd40;             // info header size
    hb[144 +: 32] = 32'(w);             // width
    hb[176 +: 32] = 32'(-h);            // negative height: rows stored top-down
    hb[208 +: 16] = 16'd1;              // planes
    hb[224 +: 16] = 16'd24;             // bits per pixel
    hb[272 +: 32] = img;                // image size
    return hb;
  endfunction

  localparam logic [431:0] HDR = build_header(WIDTH, HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PIXELS,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            vsync_q;
  logic [3:0]      hdr_cnt_q, hdr_cnt_d;
  logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [47:0]     mem_q [FIFO_DEPTH];

  logic            vsync_rise;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            hdr_xfer;
  logic            flush;
  logic [47:0]     hdr_beat;
  logic [47:0]     pair_dat;

  assign vsync_rise = bus.VSYNC & ~vsync_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push_req   = bus.HSYNC && (state_q == S_HEADER || state_q == S_PIXELS);
  assign pop        = (state_q == S_PIXELS) && !fifo_empty && bus.out_ready;
  // A full FIFO still takes a pair when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign hdr_xfer   = (state_q == S_HEADER) && bus.out_ready;
  // Starting a frame discards anything left over from the previous one.
  assign flush      = (state_q == S_IDLE || state_q == S_DONE) && vsync_rise;
  // Byte 0 = B0 ... byte 5 = R1.
  assign pair_dat   = {bus.DATA_R1, bus.DATA_G1, bus.DATA_B1,
                       bus.DATA_R0, bus.DATA_G0, bus.DATA_B0};

  // Select the current 6-byte header beat.
  always_comb begin
    hdr_beat = '0;
    for (int k = 0; k < 9; k++) begin
      if (hdr_cnt_q == 4'(k)) hdr_beat = HDR[48*k +: 48];
    end
  end

  // Frame sequencing: next state and header/pixel beat counters.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    pix_cnt_d = pix_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (vsync_rise) begin
          state_d   = S_HEADER;
          hdr_cnt_d = '0;
          pix_cnt_d = '0;
        end
      end
      S_HEADER: begin
        if (hdr_xfer) begin
          if (hdr_cnt_q == 4'd8) state_d = S_PIXELS;
          else                   hdr_cnt_d = hdr_cnt_q + 4'd1;
        end
      end
      S_PIXELS: begin
        if (pop) begin
          pix_cnt_d = pix_cnt_q + CW'(1);
          if (pix_cnt_q == CW'(NBEATS - 1)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer/occupancy update and sticky drop flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_req & ~push);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q   <= S_IDLE;
      vsync_q   <= 1'b0;
      hdr_cnt_q <= '0;
      pix_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= bus.VSYNC;
      hdr_cnt_q <= hdr_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; contents only matter behind the occupancy count, so no reset.
  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= pair_dat;
  end

  // Output mux: header beats, then FIFO head; quiet in IDLE and DONE.
  always_comb begin
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.frame_done = (state_q == S_DONE);
    bus.overflow   = ovf_q;
    case (state_q)
      S_HEADER: begin
        bus.out_valid = 1'b1;
        bus.out_data  = hdr_beat;
      end
      S_PIXELS: begin
        bus.out_valid = !fifo_empty;
        bus.out_data  = mem_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

endmodule
